// File: rtl/serial_rx_pkg.sv
// rtl/serial_rx_pkg.sv - shared state encoding and frame helpers for the serial receiver
package serial_rx_pkg;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = S_IDLE,
        DATA   = S_DATA,
        PARITY = S_PARITY,
        STOP   = S_STOP
    } state_t;

    // Total line cycles of one frame: start + data + optional parity + stop.
    function automatic int frame_len(input int n, input int parity_en);
        return n + 2 + parity_en;
    endfunction

endpackage

// File: rtl/rx_bit_shifter.sv
// rtl/rx_bit_shifter.sv - indexed one-bit-per-cycle capture register for received data
module rx_bit_shifter #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_en,
    input  logic [$clog2(N)-1:0] bit_idx,
    input  logic                 bit_in,
    input  logic                 clr,
    output logic [N-1:0]         data
);

    // Clear at frame start, otherwise steer the incoming bit to its slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data <= '0;
        end else if (clr) begin
            data <= '0;
        end else if (load_en) begin
            data[bit_idx] <= bit_in;
        end
    end

endmodule

// File: rtl/serial_rx_frame_ctrl.sv
// rtl/serial_rx_frame_ctrl.sv - framed serial receiver with parity/stop checks and one-entry output buffer
module serial_rx_frame_ctrl
    import serial_rx_pkg::*;
#(
    parameter int N         = 8,
    parameter int PARITY_EN = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         data_in,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    output logic         parity_err,
    output logic         frame_err,
    output logic         overrun,
    output logic         busy
);

    localparam int CW = $clog2(N);

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   bit_cnt;
    logic [CW-1:0]   bit_cnt_nxt;
    logic            par_ok;
    logic [N-1:0]    shift_data;
    logic            clr;
    logic            load_en;
    logic            ferr_d;
    logic            perr_d;
    logic            word_good;

    rx_bit_shifter #(.N(N)) u_shifter (
        .clk     (clk),
        .reset   (reset),
        .load_en (load_en),
        .bit_idx (bit_cnt),
        .bit_in  (data_in),
        .clr     (clr),
        .data    (shift_data)
    );

    // Frame sequencing: next state, bit counter and stop-bit verdict.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        clr         = 1'b0;
        load_en     = 1'b0;
        ferr_d      = 1'b0;
        perr_d      = 1'b0;
        word_good   = 1'b0;
        case (state)
            IDLE: begin
                if (enable && !data_in) begin
                    state_nxt   = DATA;
                    bit_cnt_nxt = '0;
                    clr         = 1'b1;
                end
            end
            DATA: begin
                load_en = 1'b1;
                if (bit_cnt == CW'(N - 1)) begin
                    state_nxt   = (PARITY_EN != 0) ? PARITY : STOP;
                    bit_cnt_nxt = '0;
                end else begin
                    bit_cnt_nxt = bit_cnt + 1'b1;
                end
            end
            PARITY: begin
                state_nxt = STOP;
            end
            STOP: begin
                state_nxt = IDLE;
                // A low stop bit outranks a parity mismatch.
                if (!data_in) begin
                    ferr_d = 1'b1;
                end else if (!par_ok) begin
                    perr_d = 1'b1;
                end else begin
                    word_good = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and bit counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
        end
    end

    // Parity verdict; frames without a parity bit are always parity-clean.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_ok <= 1'b0;
        end else if (clr) begin
            par_ok <= 1'b1;
        end else if (state == PARITY) begin
            par_ok <= (data_in == ^shift_data);
        end
    end

    // Output buffer, handshake and registered error/overrun pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err  <= ferr_d;
            parity_err <= perr_d;
            overrun    <= 1'b0;
            if (word_good && (!out_valid || out_ready)) begin
                out_data  <= shift_data;
                out_valid <= 1'b1;
            end else begin
                if (word_good) begin
                    overrun <= 1'b1;
                end
                if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_rx_frame_ctrl.sv
// tb/tb_serial_rx_frame_ctrl.sv - scoreboard bench for serial_rx_frame_ctrl
module tb_serial_rx_frame_ctrl;
    import serial_rx_pkg::*;

    localparam int N  = 8;
    localparam int PE = 1;

    localparam int K_LOAD = 0;
    localparam int K_FERR = 1;
    localparam int K_PERR = 2;
    localparam int K_OVR  = 3;

    typedef struct {
        int       kind;
        logic [7:0] data;
        int       cyc;
    } ev_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b1;
    logic         data_in = 1'b1;
    logic         out_ready = 1'b0;
    logic         out_valid;
    logic [N-1:0] out_data;
    logic         parity_err;
    logic         frame_err;
    logic         overrun;
    logic         busy;

    serial_rx_frame_ctrl #(.N(N), .PARITY_EN(PE)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .data_in    (data_in),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_pass = 0;
    int n_total = 0;

    ev_t        evq[$];
    logic [7:0] xq[$];
    int         occ = 0;
    int         rdy_mode = 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        else n_pass++;
    endtask

    // One line cycle; also advances the one-slot buffer model by any transfer.
    task automatic drive(input logic b, input int rdy_force);
        @(posedge clk);
        #1;
        data_in = b;
        if (rdy_force >= 0) out_ready = (rdy_force != 0);
        else if (rdy_mode == 2) out_ready = ($urandom_range(0, 9) < 6);
        else out_ready = (rdy_mode != 0);
        if (occ > 0 && out_ready) occ = 0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) drive(1'b1, -1);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_bad,
                              input logic stop_bit, input int stop_rdy);
        int sc;
        ev_t e;
        drive(1'b0, -1);
        sc = cyc;
        for (int i = 0; i < N; i++) drive(d[i], -1);
        drive((^d) ^ par_bad, -1);
        drive(stop_bit, stop_rdy);
        e.data = d;
        e.cyc  = sc + frame_len(N, PE);
        if (!stop_bit) e.kind = K_FERR;
        else if (par_bad) e.kind = K_PERR;
        else if (occ == 0) begin
            e.kind = K_LOAD;
            xq.push_back(d);
            occ = 1;
        end else e.kind = K_OVR;
        evq.push_back(e);
    endtask

    // Monitor: pops expected events on pulses/loads and expected words on transfers.
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data = '0;

    task automatic expect_ev(input int kind);
        ev_t e;
        if (evq.size() == 0) begin
            chk("unexpected_event", kind, 32'hFFFF);
        end else begin
            e = evq.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_cycle", cyc, e.cyc);
            if (kind == K_LOAD) chk("load_data", out_data, e.data);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            prev_data  = '0;
        end else begin
            if (prev_valid && !prev_ready) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_data", out_data, prev_data);
            end
            if (frame_err)  expect_ev(K_FERR);
            if (parity_err) expect_ev(K_PERR);
            if (overrun)    expect_ev(K_OVR);
            if (out_valid && (!prev_valid || prev_ready)) expect_ev(K_LOAD);
            if (out_valid && out_ready) begin
                if (xq.size() == 0) chk("unexpected_xfer", out_data, 32'hFFFF);
                else chk("xfer_data", out_data, xq.pop_front());
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_data  = out_data;
        end
    end

    initial begin
        logic [7:0] d;
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_perr", parity_err, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        idle(2);

        // Good frame, parity error, frame error over parity error, recovery.
        rdy_mode = 1;
        send_frame(8'hA5, 1'b0, 1'b1, -1);
        idle(2);
        send_frame(8'hA5, 1'b1, 1'b1, -1);
        idle(2);
        send_frame(8'h3C, 1'b1, 1'b0, -1);
        send_frame(8'h01, 1'b0, 1'b1, -1);
        idle(3);

        // Full buffer: second word overruns, then drains.
        rdy_mode = 0;
        send_frame(8'h11, 1'b0, 1'b1, -1);
        send_frame(8'h22, 1'b0, 1'b1, -1);
        idle(2);
        rdy_mode = 1;
        idle(2);
        @(negedge clk);
        chk("drained_valid", out_valid, 0);

        // Consume on the exact load cycle: no overrun, data swaps in one cycle.
        rdy_mode = 0;
        send_frame(8'h11, 1'b0, 1'b1, -1);
        send_frame(8'h22, 1'b0, 1'b1, 1);
        rdy_mode = 1;
        idle(3);

        // Reset during data bit 4 aborts silently.
        drive(1'b0, -1);
        d = 8'h5A;
        for (int i = 0; i < 4; i++) drive(d[i], -1);
        @(posedge clk);
        #1 reset = 1'b1;
        data_in = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_pulses", {parity_err, frame_err, overrun}, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        occ = 0;
        send_frame(8'hFF, 1'b0, 1'b1, -1);
        idle(2);

        // Start bit with enable low is ignored.
        @(posedge clk);
        #1 enable = 1'b0;
        data_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("disabled_busy", busy, 0);
        drive(1'b1, -1);
        enable = 1'b1;
        idle(1);

        // Randomized frames, errors, gaps and backpressure.
        rdy_mode = 2;
        for (int f = 0; f < 150; f++) begin
            logic pb;
            logic sb;
            d  = 8'($urandom);
            pb = ($urandom_range(0, 5) == 0);
            sb = ($urandom_range(0, 5) != 0);
            send_frame(d, pb, sb, -1);
            idle($urandom_range(0, 2));
        end
        rdy_mode = 1;
        idle(4);
        @(negedge clk);
        chk("events_left", evq.size(), 0);
        chk("words_left", xq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
